mem_port_arbiter: RTL

- Shares one SRAM-like memory port between the instruction-fetch requester and the data (load/store) requester.
- Sits between the pipeline's fetch and memory stages and the single downstream bus bridge.
- Arbitrates one transaction at a time, with data priority and a starvation guard for fetch.
- Drops instruction responses that are cancelled by pipeline flushes.

---
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  mem_port_arbiter -- shares one memory port between fetch and load/store,
//  data-priority arbitration with a fetch starvation guard.  Rev 1.0
// ============================================================================
module mem_port_arbiter #(
   parameter int MAX_STREAK = 4,
   parameter int STREAK_W   = 3
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   input  logic        inst_cancel,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,

   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,

   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata,

   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [STREAK_W-1:0] c_MAX_STREAK = STREAK_W'(MAX_STREAK);
   localparam logic                c_GUARD_EN   = (MAX_STREAK != 0);

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_owner_data;
   logic                  r_cancelled;
   logic [STREAK_W-1:0]   r_streak;
   logic                  r_mem_wr;
   logic [1:0]            r_mem_size;
   logic [3:0]            r_mem_wstrb;
   logic [31:0]           r_mem_addr;
   logic [31:0]           r_mem_wdata;

   logic                  w_contention;
   logic                  w_force_inst;
   logic                  w_grant_data;
   logic                  w_grant_inst;
   logic                  w_resp_done;

   assign w_contention = data_req & inst_req;
   assign w_force_inst = c_GUARD_EN & w_contention & (r_streak == c_MAX_STREAK);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_grant_data = 1'b0;
      w_grant_inst = 1'b0;
      w_resp_done  = 1'b0;
      mem_req      = 1'b0;
      busy         = 1'b1;
      case (r_state)
         ST_IDLE: begin
            busy = 1'b0;
            if (data_req && !w_force_inst) begin
               w_grant_data = 1'b1;
            end else if (inst_req && !inst_cancel) begin
               w_grant_inst = 1'b1;
            end
            if (w_grant_data || w_grant_inst) begin
               w_state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            mem_req = 1'b1;
            if (mem_addr_ok) begin
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            if (mem_data_ok) begin
               w_resp_done = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign inst_addr_ok = w_grant_inst;
   assign data_addr_ok = w_grant_data;

   // A cancel arriving in the same cycle as the response must also suppress it.
   assign inst_data_ok = w_resp_done & ~r_owner_data & ~r_cancelled & ~inst_cancel;
   assign data_data_ok = w_resp_done & r_owner_data;

   assign inst_rdata = (r_state == ST_RESP && !r_owner_data) ? mem_rdata : 32'd0;
   assign data_rdata = (r_state == ST_RESP &&  r_owner_data) ? mem_rdata : 32'd0;

   assign mem_wr    = r_mem_wr;
   assign mem_size  = r_mem_size;
   assign mem_wstrb = r_mem_wstrb;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner_data <= 1'b0;
         r_mem_wr     <= 1'b0;
         r_mem_size   <= 2'd0;
         r_mem_wstrb  <= 4'd0;
         r_mem_addr   <= 32'd0;
         r_mem_wdata  <= 32'd0;
      end else if (w_grant_data) begin
         r_owner_data <= 1'b1;
         r_mem_wr     <= data_wr;
         r_mem_size   <= data_size;
         r_mem_wstrb  <= data_wstrb;
         r_mem_addr   <= data_addr;
         r_mem_wdata  <= data_wdata;
      end else if (w_grant_inst) begin
         r_owner_data <= 1'b0;
         r_mem_wr     <= 1'b0;
         r_mem_size   <= 2'd2;
         r_mem_wstrb  <= 4'd0;
         r_mem_addr   <= inst_addr;
         r_mem_wdata  <= 32'd0;
      end
   end

   // Streak only grows while fetch is actually waiting; saturates at the limit.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_streak <= '0;
      end else if (w_grant_data) begin
         if (!w_contention) begin
            r_streak <= '0;
         end else if (r_streak != c_MAX_STREAK) begin
            r_streak <= r_streak + STREAK_W'(1);
         end
      end else if (w_grant_inst) begin
         r_streak <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cancelled <= 1'b0;
      end else if (r_state == ST_IDLE) begin
         r_cancelled <= 1'b0;
      end else if (!r_owner_data && inst_cancel) begin
         r_cancelled <= 1'b1;
      end
   end

endmodule
`default_nettype wire
